// File: rtl/valu_pkg.sv
// Shared opcode type and default sizing for the vector ALU pipeline.
package valu_pkg;

   typedef enum logic [1:0] {
      VALU_ADD = 2'b00,
      VALU_SUB = 2'b01,
      VALU_MUL = 2'b10,
      VALU_MAC = 2'b11
   } valu_op_e;

   localparam int unsigned VALU_LANES = 16;
   localparam int unsigned VALU_EW    = 32;

endpackage

// File: rtl/valu_lane.sv
// One lane of the vector ALU: sign-extended add/sub/mul and, when VALU_ACC_EN is
// defined, a wrapping multiply-accumulate register.
module valu_lane
   import valu_pkg::*;
#(
   parameter int unsigned EW = VALU_EW
) (
   input  logic            clk,
   input  logic            rst,
   input  valu_op_e        op,
   input  logic [EW-1:0]   a,
   input  logic [EW-1:0]   b,
   input  logic            acc_clr,
   input  logic            move,
   output logic [2*EW-1:0] res
);

   localparam int unsigned RW = 2 * EW;

   logic signed [RW-1:0] a_ext;
   logic signed [RW-1:0] b_ext;
   logic signed [RW-1:0] prod;

   assign a_ext = {{EW{a[EW-1]}}, a};
   assign b_ext = {{EW{b[EW-1]}}, b};
   assign prod  = a_ext * b_ext;

`ifdef VALU_ACC_EN
   logic [RW-1:0] acc_q;
   logic [RW-1:0] acc_base;
   logic [RW-1:0] acc_sum;

   // A clear coinciding with a MAC move takes effect before the add.
   assign acc_base = acc_clr ? '0 : acc_q;
   assign acc_sum  = acc_base + prod;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
      end else if (move && (op == VALU_MAC)) begin
         acc_q <= acc_sum;
      end else if (acc_clr) begin
         acc_q <= '0;
      end
   end
`else
   logic unused_acc;
   assign unused_acc = ^{clk, rst, acc_clr, move};
`endif

   always_comb begin
      res = prod;
      case (op)
         VALU_ADD: res = a_ext + b_ext;
         VALU_SUB: res = a_ext - b_ext;
`ifdef VALU_ACC_EN
         VALU_MAC: res = acc_sum;
`endif
         default:  res = prod;
      endcase
   end

endmodule

// File: rtl/vector_alu_pipe.sv
// Pipelined signed vector ALU: operand stage S1 and result stage S2 with valid/ready
// flow control. Define VALU_ACC_EN to build the per-lane multiply-accumulate.
module vector_alu_pipe
   import valu_pkg::*;
#(
   parameter int unsigned LANES = VALU_LANES,
   parameter int unsigned EW    = VALU_EW
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [1:0]            op,
   input  logic [LANES*EW-1:0]   a,
   input  logic [LANES*EW-1:0]   b,
   input  logic                  acc_clr,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [LANES*2*EW-1:0] result
);

   localparam int unsigned RW = 2 * EW;

   logic                s1_v_q;
   valu_op_e            s1_op_q;
   logic [LANES*EW-1:0] s1_a_q;
   logic [LANES*EW-1:0] s1_b_q;
   logic                out_valid_q;
   logic [LANES*RW-1:0] result_q;
   logic [LANES*RW-1:0] lane_res;

   logic adv2;
   logic move;
   logic accept;

   assign adv2     = !out_valid_q || out_ready;
   assign move     = s1_v_q && adv2;
   assign in_ready = !s1_v_q || adv2;
   assign accept   = in_valid && in_ready;

   assign out_valid = out_valid_q;
   assign result    = result_q;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      valu_lane #(
         .EW(EW)
      ) u_lane (
         .clk    (clk),
         .rst    (rst),
         .op     (s1_op_q),
         .a      (s1_a_q[i*EW +: EW]),
         .b      (s1_b_q[i*EW +: EW]),
         .acc_clr(acc_clr),
         .move   (move),
         .res    (lane_res[i*RW +: RW])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_v_q      <= 1'b0;
         s1_op_q     <= VALU_ADD;
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
      end else begin
         // S1 empties when its beat moves on and refills with whatever is offered.
         if (in_ready) begin
            s1_v_q <= in_valid;
         end
         if (accept) begin
            s1_op_q <= valu_op_e'(op);
            s1_a_q  <= a;
            s1_b_q  <= b;
         end
         if (adv2) begin
            out_valid_q <= s1_v_q;
         end
         if (move) begin
            result_q <= lane_res;
         end
      end
   end

endmodule

// File: tb/tb_vector_alu_pipe.sv
// Self-checking bench for vector_alu_pipe: directed vector table, hand-written
// latency/backpressure/reset sequences, and randomized beats against a lane model.
module tb_vector_alu_pipe;

   localparam int LANES = 16;
   localparam int EW    = 32;
   localparam int RW    = 64;
`ifdef VALU_ACC_EN
   localparam bit ACC_EN = 1'b1;
`else
   localparam bit ACC_EN = 1'b0;
`endif

   logic                clk;
   logic                rst;
   logic                in_valid;
   logic                in_ready;
   logic [1:0]          op;
   logic [LANES*EW-1:0] a;
   logic [LANES*EW-1:0] b;
   logic                acc_clr;
   logic                out_valid;
   logic                out_ready;
   logic [LANES*RW-1:0] result;

   vector_alu_pipe #(
      .LANES(LANES),
      .EW   (EW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .op       (op),
      .a        (a),
      .b        (b),
      .acc_clr  (acc_clr),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .result   (result)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_fail   = 0;

   logic [LANES*RW-1:0] exp_q[$];
   logic [LANES*RW-1:0] cur_exp;
   longint              macc[LANES];
   int                  ready_mode = 0;
   int                  cyc = 0;
   bit                  prev_stall = 0;
   logic [LANES*RW-1:0] prev_result;

   task automatic check1(input string name, input logic got, input logic want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s got=%b want=%b t=%0t", name, got, want, $time);
      end
   endtask

   task automatic check_vec(input string name, input logic [LANES*RW-1:0] got,
                            input logic [LANES*RW-1:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         for (int i = 0; i < LANES; i++) begin
            if (got[i*RW +: RW] !== want[i*RW +: RW]) begin
               $display("FAIL %s lane%0d got=%h want=%h t=%0t", name, i,
                        got[i*RW +: RW], want[i*RW +: RW], $time);
               break;
            end
         end
      end
   endtask

   // Reference: each lane is plain signed integer arithmetic on 64-bit longints.
   function automatic logic [LANES*RW-1:0] model(input logic [1:0] o,
                                                  input logic [LANES*EW-1:0] va,
                                                  input logic [LANES*EW-1:0] vb);
      logic [LANES*RW-1:0] r;
      int     ai;
      int     bi;
      longint x;
      longint y;
      longint v;
      for (int i = 0; i < LANES; i++) begin
         ai = va[i*EW +: EW];
         bi = vb[i*EW +: EW];
         x  = ai;
         y  = bi;
         case (o)
            2'd0:    v = x + y;
            2'd1:    v = x - y;
            2'd2:    v = x * y;
            default: begin
               if (ACC_EN) begin
                  macc[i] = macc[i] + x * y;
                  v = macc[i];
               end else begin
                  v = x * y;
               end
            end
         endcase
         r[i*RW +: RW] = v;
      end
      return r;
   endfunction

   function automatic logic [LANES*EW-1:0] rand_vec();
      logic [LANES*EW-1:0] v;
      for (int i = 0; i < LANES; i++) v[i*EW +: EW] = $urandom;
      return v;
   endfunction

   always @(posedge clk) begin
      #1;
      cyc++;
      case (ready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = (cyc % 3 == 0);
         2:       out_ready = 1'($urandom_range(0, 1));
         default: out_ready = 1'b0;
      endcase
   end

   // Scoreboard: handshake rule, stall stability, in-order result compare.
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 0;
      end else begin
         check1("in_ready", in_ready, !(exp_q.size() == 2 && !out_ready));
         if (prev_stall) begin
            check1("stall_valid_hold", out_valid, 1'b1);
            check_vec("stall_result_hold", result, prev_result);
         end
         if (out_valid === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_out_valid got=1 want=0 t=%0t", $time);
            end else if (out_ready) begin
               check_vec("result", result, exp_q.pop_front());
            end
         end
         prev_stall  = out_valid && !out_ready;
         prev_result = result;
         if (in_valid && in_ready) exp_q.push_back(cur_exp);
      end
   end

   // Offer one beat and hold it until accepted; returns just after the capture edge.
   task automatic send(input logic [1:0] o, input logic [LANES*EW-1:0] va,
                       input logic [LANES*EW-1:0] vb, input logic [LANES*RW-1:0] e);
      bit done;
      done     = 0;
      op       = o;
      a        = va;
      b        = vb;
      cur_exp  = e;
      in_valid = 1'b1;
      for (int t = 0; t < 200 && !done; t++) begin
         @(negedge clk);
         done = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      n_checks++;
      if (!done) begin
         n_fail++;
         $display("FAIL send_timeout got=not_accepted want=accepted t=%0t", $time);
      end
   endtask

   task automatic send_model(input logic [1:0] o, input logic [LANES*EW-1:0] va,
                             input logic [LANES*EW-1:0] vb);
      send(o, va, vb, model(o, va, vb));
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain_timeout got=%0d want=0 t=%0t", exp_q.size(), $time);
      end
   endtask

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a0;
      logic [31:0] b0;
      logic [31:0] a15;
      logic [31:0] b15;
      logic        clr;
      logic [63:0] e0;
      logic [63:0] e15;
   } vec_t;

   vec_t tbl[13];

   initial begin
      logic [LANES*EW-1:0] va;
      logic [LANES*EW-1:0] vb;
      logic [LANES*RW-1:0] ve;

      tbl[0]  = '{2'd0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 32'hFFFFFFFF, 1'b0,
                  64'h0000000080000000, 64'hFFFFFFFF7FFFFFFF};
      tbl[1]  = '{2'd1, 32'd5, 32'd7, 32'h80000000, 32'h7FFFFFFF, 1'b0,
                  64'hFFFFFFFFFFFFFFFE, 64'hFFFFFFFF00000001};
      tbl[2]  = '{2'd2, 32'h80000000, 32'h80000000, 32'hFFFFFFFD, 32'd4, 1'b0,
                  64'h4000000000000000, 64'hFFFFFFFFFFFFFFF4};
      tbl[3]  = '{2'd2, 32'h7FFFFFFF, 32'h80000000, 32'h0, 32'h0, 1'b0,
                  64'hC000000080000000, 64'h0};
      tbl[4]  = '{2'd3, 32'd3, 32'd4, 32'h0, 32'h0, 1'b0, 64'd12, 64'h0};
      tbl[5]  = '{2'd3, 32'hFFFFFFFE, 32'd5, 32'h0, 32'h0, 1'b0,
                  ACC_EN ? 64'd2 : 64'hFFFFFFFFFFFFFFF6, 64'h0};
      tbl[6]  = '{2'd3, 32'd10, 32'd10, 32'h0, 32'h0, 1'b0,
                  ACC_EN ? 64'd102 : 64'd100, 64'h0};
      tbl[7]  = '{2'd3, 32'd2, 32'd2, 32'h0, 32'h0, 1'b1, 64'd4, 64'h0};
      tbl[8]  = '{2'd3, 32'd1, 32'd1, 32'h0, 32'h0, 1'b0,
                  ACC_EN ? 64'd5 : 64'd1, 64'h0};
      tbl[9]  = '{2'd3, 32'h80000000, 32'h80000000, 32'h0, 32'h0, 1'b1,
                  64'h4000000000000000, 64'h0};
      tbl[10] = '{2'd3, 32'h80000000, 32'h80000001, 32'h0, 32'h0, 1'b0,
                  ACC_EN ? 64'h7FFFFFFF80000000 : 64'h3FFFFFFF80000000, 64'h0};
      tbl[11] = '{2'd3, 32'h7FFFFFFF, 32'h1, 32'h0, 32'h0, 1'b0,
                  ACC_EN ? 64'h7FFFFFFFFFFFFFFF : 64'h000000007FFFFFFF, 64'h0};
      tbl[12] = '{2'd3, 32'd1, 32'd1, 32'h0, 32'h0, 1'b0,
                  ACC_EN ? 64'h8000000000000000 : 64'd1, 64'h0};

      for (int i = 0; i < LANES; i++) macc[i] = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      op        = 2'd0;
      a         = '0;
      b         = '0;
      acc_clr   = 1'b0;
      out_ready = 1'b1;
      cur_exp   = '0;

      repeat (3) @(posedge clk);
      #1;
      check1("reset_out_valid", out_valid, 1'b0);
      check1("reset_in_ready", in_ready, 1'b1);
      check_vec("reset_result", result, '0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Operand register then result register: valid one edge after capture.
      send_model(2'd0, rand_vec(), rand_vec());
      check1("latency_capture_edge", out_valid, 1'b0);
      @(posedge clk);
      #1;
      check1("latency_next_edge", out_valid, 1'b1);
      wait_drain();

      foreach (tbl[k]) begin
         va = '0;
         vb = '0;
         ve = '0;
         va[0 +: EW]       = tbl[k].a0;
         vb[0 +: EW]       = tbl[k].b0;
         va[15*EW +: EW]   = tbl[k].a15;
         vb[15*EW +: EW]   = tbl[k].b15;
         ve[0 +: RW]       = tbl[k].e0;
         ve[15*RW +: RW]   = tbl[k].e15;
         acc_clr = tbl[k].clr;
         send(tbl[k].op, va, vb, ve);
         // Hold the clear into the cycle the beat moves to S2 as well.
         @(posedge clk);
         #1;
         acc_clr = 1'b0;
         wait_drain();
      end

      // Clear alone while idle; model restarts from zero.
      acc_clr = 1'b1;
      @(posedge clk);
      #1;
      acc_clr = 1'b0;
      for (int i = 0; i < LANES; i++) macc[i] = 0;

      ready_mode = 1;
      for (int k = 0; k < 6; k++) send_model(2'($urandom_range(0, 3)), rand_vec(), rand_vec());
      wait_drain();

      ready_mode = 2;
      for (int k = 0; k < 150; k++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
         send_model(2'($urandom_range(0, 3)), rand_vec(), rand_vec());
      end
      ready_mode = 0;
      wait_drain();

      // Reset with both stages occupied.
      ready_mode = 3;
      @(posedge clk);
      #1;
      send_model(2'd0, rand_vec(), rand_vec());
      send_model(2'd1, rand_vec(), rand_vec());
      #2;
      rst = 1'b1;
      exp_q.delete();
      for (int i = 0; i < LANES; i++) macc[i] = 0;
      #1;
      check1("midrst_out_valid", out_valid, 1'b0);
      check1("midrst_in_ready", in_ready, 1'b1);
      check_vec("midrst_result", result, '0);
      ready_mode = 0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      va = '0;
      vb = '0;
      for (int i = 0; i < LANES; i++) begin
         va[i*EW +: EW] = 32'd1;
         vb[i*EW +: EW] = 32'd1;
      end
      send_model(2'd3, va, vb);
      wait_drain();
      repeat (3) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
